// File: rtl/ex_writeback_pipe_if.sv
// ex_writeback_pipe_if
//
// Bundles every data-path signal of the result-return pipeline so the
// pipeline and its neighbours connect through one port.
//
// Signal groups:
//   EX  : regWriteEnable_EXn, readRegisterRT_EXn, result_EXn
//         (execution results entering the pipeline, one set per pipe)
//   REG : readRegisterRA/RB/RC_REGn, readDataRA/RB/RC_REGn
//         (REG-stage source register numbers and register-file read data)
//   FWD : readDataRA/RB/RC_FWDn
//         (operand data after forwarding, heading toward EX)
//   WB  : regWriteEnable_WBn, writeRegister_WBn, writeData_WBn
//         (register-file write ports)
//
// Modports:
//   master : the surrounding core (drives EX/REG, receives FWD/WB)
//   slave  : ex_writeback_pipe itself
interface ex_writeback_pipe_if;

    // Execution results entering the pipeline
    logic         regWriteEnable_EX1;
    logic         regWriteEnable_EX2;
    logic [6:0]   readRegisterRT_EX1;
    logic [6:0]   readRegisterRT_EX2;
    logic [127:0] result_EX1;
    logic [127:0] result_EX2;

    // REG-stage lookups and register-file read data
    logic [6:0]   readRegisterRA_REG1;
    logic [6:0]   readRegisterRB_REG1;
    logic [6:0]   readRegisterRC_REG1;
    logic [6:0]   readRegisterRA_REG2;
    logic [6:0]   readRegisterRB_REG2;
    logic [6:0]   readRegisterRC_REG2;
    logic [127:0] readDataRA_REG1;
    logic [127:0] readDataRB_REG1;
    logic [127:0] readDataRC_REG1;
    logic [127:0] readDataRA_REG2;
    logic [127:0] readDataRB_REG2;
    logic [127:0] readDataRC_REG2;

    // Forwarded operand data
    logic [127:0] readDataRA_FWD1;
    logic [127:0] readDataRB_FWD1;
    logic [127:0] readDataRC_FWD1;
    logic [127:0] readDataRA_FWD2;
    logic [127:0] readDataRB_FWD2;
    logic [127:0] readDataRC_FWD2;

    // Register-file write ports
    logic         regWriteEnable_WB1;
    logic         regWriteEnable_WB2;
    logic [6:0]   writeRegister_WB1;
    logic [6:0]   writeRegister_WB2;
    logic [127:0] writeData_WB1;
    logic [127:0] writeData_WB2;

    modport master (
        output regWriteEnable_EX1, regWriteEnable_EX2,
        output readRegisterRT_EX1, readRegisterRT_EX2,
        output result_EX1, result_EX2,
        output readRegisterRA_REG1, readRegisterRB_REG1, readRegisterRC_REG1,
        output readRegisterRA_REG2, readRegisterRB_REG2, readRegisterRC_REG2,
        output readDataRA_REG1, readDataRB_REG1, readDataRC_REG1,
        output readDataRA_REG2, readDataRB_REG2, readDataRC_REG2,
        input  readDataRA_FWD1, readDataRB_FWD1, readDataRC_FWD1,
        input  readDataRA_FWD2, readDataRB_FWD2, readDataRC_FWD2,
        input  regWriteEnable_WB1, regWriteEnable_WB2,
        input  writeRegister_WB1, writeRegister_WB2,
        input  writeData_WB1, writeData_WB2
    );

    modport slave (
        input  regWriteEnable_EX1, regWriteEnable_EX2,
        input  readRegisterRT_EX1, readRegisterRT_EX2,
        input  result_EX1, result_EX2,
        input  readRegisterRA_REG1, readRegisterRB_REG1, readRegisterRC_REG1,
        input  readRegisterRA_REG2, readRegisterRB_REG2, readRegisterRC_REG2,
        input  readDataRA_REG1, readDataRB_REG1, readDataRC_REG1,
        input  readDataRA_REG2, readDataRB_REG2, readDataRC_REG2,
        output readDataRA_FWD1, readDataRB_FWD1, readDataRC_FWD1,
        output readDataRA_FWD2, readDataRB_FWD2, readDataRC_FWD2,
        output regWriteEnable_WB1, regWriteEnable_WB2,
        output writeRegister_WB1, writeRegister_WB2,
        output writeData_WB1, writeData_WB2
    );

endinterface

// File: rtl/ex_writeback_pipe.sv
// ex_writeback_pipe
//
// Result-return pipeline of the dual-issue SPU. The two per-cycle execution
// results (pipe 1 / pipe 2) travel through DEPTH staged slots and leave from
// the last slot on the register-file write ports. Every valid in-flight
// result can be forwarded to the six REG-stage operand lookups.
//
// Parameters:
//   DEPTH  number of result stages between EX and writeback (2..8)
//
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous, active-high; clears every slot
//   stall  holds every slot and suppresses writeback
//   flush  kills in-flight results that have not reached the last slot
//   bus    ex_writeback_pipe_if.slave (EX inputs, REG lookups, FWD, WB)
//
// Build option:
//   WB_FORWARD_EN  when defined the forwarding network is built; when
//                  undefined the FWD outputs are a plain copy of the REG
//                  read data and the issue logic has to interlock instead.
module ex_writeback_pipe #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    ex_writeback_pipe_if.slave   bus
);

    // Slot storage, indexed [pipe][stage]; pipe 0 is pipe 1, pipe 1 is pipe 2.
    // Stage 0 is the youngest result, stage DEPTH-1 is the one writing back.
    logic         slot_valid [2][DEPTH];
    logic [6:0]   slot_rt    [2][DEPTH];
    logic [127:0] slot_data  [2][DEPTH];

    // EX inputs gathered per pipe so both pipes share one update loop
    logic         ex_valid [2];
    logic [6:0]   ex_rt    [2];
    logic [127:0] ex_data  [2];

    assign ex_valid[0] = bus.regWriteEnable_EX1;
    assign ex_valid[1] = bus.regWriteEnable_EX2;
    assign ex_rt[0]    = bus.readRegisterRT_EX1;
    assign ex_rt[1]    = bus.readRegisterRT_EX2;
    assign ex_data[0]  = bus.result_EX1;
    assign ex_data[1]  = bus.result_EX2;

    // Slot pipeline. When advancing, a flush empties every slot: the last
    // slot still writes back this cycle and is then replaced by the cleared
    // content of the stage before it. When stalled, a flush clears only the
    // non-final slots; the last slot keeps its committed result for later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    slot_valid[p][k] <= 1'b0;
                    slot_rt[p][k]    <= '0;
                    slot_data[p][k]  <= '0;
                end
            end
        end else if (!stall) begin
            for (int p = 0; p < 2; p++) begin
                slot_valid[p][0] <= ex_valid[p] & ~flush;
                slot_rt[p][0]    <= flush ? 7'd0 : ex_rt[p];
                slot_data[p][0]  <= flush ? 128'd0 : ex_data[p];
                for (int k = 1; k < DEPTH; k++) begin
                    slot_valid[p][k] <= slot_valid[p][k-1] & ~flush;
                    slot_rt[p][k]    <= flush ? 7'd0 : slot_rt[p][k-1];
                    slot_data[p][k]  <= flush ? 128'd0 : slot_data[p][k-1];
                end
            end
        end else if (flush) begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < DEPTH - 1; k++) begin
                    slot_valid[p][k] <= 1'b0;
                    slot_rt[p][k]    <= '0;
                    slot_data[p][k]  <= '0;
                end
            end
        end
    end

    // Writeback straight from the last slot; only the strobe sees stall, so
    // there is no path from the EX inputs to the write ports.
    assign bus.regWriteEnable_WB1 = slot_valid[0][DEPTH-1] & ~stall;
    assign bus.regWriteEnable_WB2 = slot_valid[1][DEPTH-1] & ~stall;
    assign bus.writeRegister_WB1  = slot_rt[0][DEPTH-1];
    assign bus.writeRegister_WB2  = slot_rt[1][DEPTH-1];
    assign bus.writeData_WB1      = slot_data[0][DEPTH-1];
    assign bus.writeData_WB2      = slot_data[1][DEPTH-1];

    // Lookup order: 0..2 = RA/RB/RC of REG1, 3..5 = RA/RB/RC of REG2
    logic [127:0] lookup_data [6];
    logic [127:0] fwd_data    [6];

    assign lookup_data[0] = bus.readDataRA_REG1;
    assign lookup_data[1] = bus.readDataRB_REG1;
    assign lookup_data[2] = bus.readDataRC_REG1;
    assign lookup_data[3] = bus.readDataRA_REG2;
    assign lookup_data[4] = bus.readDataRB_REG2;
    assign lookup_data[5] = bus.readDataRC_REG2;

`ifdef WB_FORWARD_EN
    logic [6:0] lookup_reg [6];

    assign lookup_reg[0] = bus.readRegisterRA_REG1;
    assign lookup_reg[1] = bus.readRegisterRB_REG1;
    assign lookup_reg[2] = bus.readRegisterRC_REG1;
    assign lookup_reg[3] = bus.readRegisterRA_REG2;
    assign lookup_reg[4] = bus.readRegisterRB_REG2;
    assign lookup_reg[5] = bus.readRegisterRC_REG2;

    for (genvar i = 0; i < 6; i++) begin : g_fwd
        logic [127:0] hit_data;

        // Scan from the oldest slot to the youngest, pipe 1 before pipe 2,
        // letting each later match overwrite the earlier one. The survivor is
        // therefore the youngest match, with pipe 2 winning a tie in the same
        // stage because it is later in program order. The last slot is
        // searched even while stalled, since its result is not yet written.
        always_comb begin
            hit_data = lookup_data[i];
            for (int k = DEPTH - 1; k >= 0; k--) begin
                for (int p = 0; p < 2; p++) begin
                    if (slot_valid[p][k] && (slot_rt[p][k] == lookup_reg[i])) begin
                        hit_data = slot_data[p][k];
                    end
                end
            end
        end

        assign fwd_data[i] = hit_data;
    end
`else
    // Without forwarding the source register numbers have no consumer here.
    logic unused_lookup;
    assign unused_lookup = ^{bus.readRegisterRA_REG1, bus.readRegisterRB_REG1,
                             bus.readRegisterRC_REG1, bus.readRegisterRA_REG2,
                             bus.readRegisterRB_REG2, bus.readRegisterRC_REG2};

    for (genvar i = 0; i < 6; i++) begin : g_pass
        assign fwd_data[i] = lookup_data[i];
    end
`endif

    assign bus.readDataRA_FWD1 = fwd_data[0];
    assign bus.readDataRB_FWD1 = fwd_data[1];
    assign bus.readDataRC_FWD1 = fwd_data[2];
    assign bus.readDataRA_FWD2 = fwd_data[3];
    assign bus.readDataRB_FWD2 = fwd_data[4];
    assign bus.readDataRC_FWD2 = fwd_data[5];

endmodule

// File: tb/tb_ex_writeback_pipe.sv
// tb_ex_writeback_pipe
//
// Directed bench for ex_writeback_pipe (DEPTH=4). Each issued result that
// must reach the register file is queued with the cycle it is due; a monitor
// on the falling edge pops and compares every write strobe it sees.
// Forwarding lookups are compared in-line against hand-derived values; when
// WB_FORWARD_EN is undefined the expected FWD value is the REG read data.
module tb_ex_writeback_pipe;

    localparam int DEPTH = 4;

    localparam logic [127:0] REG_RA1 = {4{32'h1A1A_0001}};
    localparam logic [127:0] REG_RB1 = {4{32'h1B1B_0002}};
    localparam logic [127:0] REG_RC1 = {4{32'h1C1C_0003}};
    localparam logic [127:0] REG_RA2 = {4{32'h2A2A_0004}};
    localparam logic [127:0] REG_RB2 = {4{32'h2B2B_0005}};
    localparam logic [127:0] REG_RC2 = {4{32'h2C2C_0006}};
    localparam logic [6:0]   NO_REG  = 7'd100;

    logic clk = 1'b0;
    logic reset;
    logic stall;
    logic flush;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [6:0]   rt;
        logic [127:0] data;
        int           cycle;
    } wb_t;

    wb_t q1[$];
    wb_t q2[$];

    ex_writeback_pipe_if bus();

    ex_writeback_pipe #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [127:0] fwdExp(input logic [127:0] hit, input logic [127:0] reg_data);
`ifdef WB_FORWARD_EN
        return hit;
`else
        return reg_data;
`endif
    endfunction

    // Drive one cycle of stimulus just after the rising edge; lat < 0 means
    // the result must never be written back.
    task automatic applyStimulus(input logic we1, input logic [6:0] rt1, input logic [127:0] d1, input int lat1,
                                 input logic we2, input logic [6:0] rt2, input logic [127:0] d2, input int lat2,
                                 input logic st, input logic fl);
        @(posedge clk);
        #1;
        bus.regWriteEnable_EX1 = we1;
        bus.readRegisterRT_EX1 = rt1;
        bus.result_EX1         = d1;
        bus.regWriteEnable_EX2 = we2;
        bus.readRegisterRT_EX2 = rt2;
        bus.result_EX2         = d2;
        stall = st;
        flush = fl;
        if (we1 && lat1 >= 0) q1.push_back('{rt: rt1, data: d1, cycle: cyc + lat1});
        if (we2 && lat2 >= 0) q2.push_back('{rt: rt2, data: d2, cycle: cyc + lat2});
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 7'd0, 128'd0, -1, 1'b0, 7'd0, 128'd0, -1, 1'b0, 1'b0);
    endtask

    task automatic setLookups(input logic [6:0] ra1, input logic [6:0] rb1, input logic [6:0] rc1,
                              input logic [6:0] ra2, input logic [6:0] rb2, input logic [6:0] rc2);
        bus.readRegisterRA_REG1 = ra1;
        bus.readRegisterRB_REG1 = rb1;
        bus.readRegisterRC_REG1 = rc1;
        bus.readRegisterRA_REG2 = ra2;
        bus.readRegisterRB_REG2 = rb2;
        bus.readRegisterRC_REG2 = rc2;
        #1;
    endtask

    task automatic monitorPipe(input int pipe, input logic en, input logic [6:0] rt, input logic [127:0] data);
        wb_t e;
        if (en === 1'b1) begin
            if ((pipe == 1 && q1.size() == 0) || (pipe == 2 && q2.size() == 0)) begin
                checks++;
                failures++;
                $display("[TB] FAIL wb%0d_unexpected: cycle %0d got write rt=%0d expected no write", pipe, cyc, rt);
            end else begin
                e = (pipe == 1) ? q1.pop_front() : q2.pop_front();
                checkOutput($sformatf("wb%0d_cycle", pipe), 128'(cyc), 128'(e.cycle));
                checkOutput($sformatf("wb%0d_rt", pipe), {121'd0, rt}, {121'd0, e.rt});
                checkOutput($sformatf("wb%0d_data", pipe), data, e.data);
            end
        end
    endtask

    // Scoreboard side: every write strobe must match the oldest queued entry
    always @(negedge clk) begin
        monitorPipe(1, bus.regWriteEnable_WB1, bus.writeRegister_WB1, bus.writeData_WB1);
        monitorPipe(2, bus.regWriteEnable_WB2, bus.writeRegister_WB2, bus.writeData_WB2);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        logic [127:0] d;

        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        bus.regWriteEnable_EX1 = 1'b0;
        bus.regWriteEnable_EX2 = 1'b0;
        bus.readRegisterRT_EX1 = '0;
        bus.readRegisterRT_EX2 = '0;
        bus.result_EX1 = '0;
        bus.result_EX2 = '0;
        bus.readDataRA_REG1 = REG_RA1;
        bus.readDataRB_REG1 = REG_RB1;
        bus.readDataRC_REG1 = REG_RC1;
        bus.readDataRA_REG2 = REG_RA2;
        bus.readDataRB_REG2 = REG_RB2;
        bus.readDataRC_REG2 = REG_RC2;
        #1;
        reset = 1'b1;
        setLookups(7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);

        // Reset state: no writes, cleared slots, rt 0 lookups miss
        #1;
        checkOutput("rst_wb1_en", {127'd0, bus.regWriteEnable_WB1}, 128'd0);
        checkOutput("rst_wb2_en", {127'd0, bus.regWriteEnable_WB2}, 128'd0);
        checkOutput("rst_wb1_data", bus.writeData_WB1, 128'd0);
        checkOutput("rst_wb2_rt", {121'd0, bus.writeRegister_WB2}, 128'd0);
        checkOutput("rst_fwd_ra1", bus.readDataRA_FWD1, REG_RA1);
        checkOutput("rst_fwd_rc2", bus.readDataRC_FWD2, REG_RC2);

        repeat (2) @(posedge clk);
        #7;
        reset = 1'b0;
        setLookups(NO_REG, NO_REG, NO_REG, NO_REG, NO_REG, NO_REG);

        // Basic latency: one result on pipe 1, written DEPTH cycles later
        $display("[TB] basic latency");
        d = {4{32'hA5A5_A5A5}};
        applyStimulus(1'b1, 7'd5, d, DEPTH, 1'b0, 7'd0, 128'd0, -1, 1'b0, 1'b0);
        idleCycles(1);
        setLookups(7'd5, NO_REG, NO_REG, NO_REG, 7'd5, NO_REG);
        checkOutput("lat_fwd_ra1_slot0", bus.readDataRA_FWD1, fwdExp(d, REG_RA1));
        checkOutput("lat_fwd_rb2_slot0", bus.readDataRB_FWD2, fwdExp(d, REG_RB2));
        idleCycles(3);
        checkOutput("lat_fwd_ra1_slot3", bus.readDataRA_FWD1, fwdExp(d, REG_RA1));
        idleCycles(1);
        checkOutput("lat_fwd_ra1_gone", bus.readDataRA_FWD1, REG_RA1);
        setLookups(NO_REG, NO_REG, NO_REG, NO_REG, NO_REG, NO_REG);
        idleCycles(DEPTH);

        // Forward priority: younger slot wins, pipe 2 wins inside a slot;
        // an invalid slot with a matching stale rt must not hit
        $display("[TB] forward priority");
        applyStimulus(1'b1, 7'd9, 128'h1, DEPTH, 1'b0, 7'd0, 128'd0, -1, 1'b0, 1'b0);
        applyStimulus(1'b0, 7'd33, 128'hDEAD, -1, 1'b1, 7'd9, 128'h2, DEPTH, 1'b0, 1'b0);
        applyStimulus(1'b1, 7'd9, 128'h3, DEPTH, 1'b1, 7'd9, 128'h4, DEPTH, 1'b0, 1'b0);
        setLookups(7'd9, 7'd33, NO_REG, NO_REG, NO_REG, NO_REG);
        checkOutput("prio_younger_slot", bus.readDataRA_FWD1, fwdExp(128'h2, REG_RA1));
        checkOutput("prio_invalid_stale_rt", bus.readDataRB_FWD1, REG_RB1);
        idleCycles(1);
        setLookups(7'd9, NO_REG, NO_REG, NO_REG, NO_REG, 7'd9);
        checkOutput("prio_pipe2_same_slot_ra1", bus.readDataRA_FWD1, fwdExp(128'h4, REG_RA1));
        checkOutput("prio_pipe2_same_slot_rc2", bus.readDataRC_FWD2, fwdExp(128'h4, REG_RC2));
        setLookups(NO_REG, NO_REG, NO_REG, NO_REG, NO_REG, NO_REG);
        idleCycles(DEPTH + 2);

        // Stall hold: result parked in the last slot for three cycles; the
        // EX2 result offered during the stall must be ignored
        $display("[TB] stall hold");
        d = {4{32'hC0DE_0012}};
        applyStimulus(1'b1, 7'd12, d, DEPTH + 3, 1'b0, 7'd0, 128'd0, -1, 1'b0, 1'b0);
        idleCycles(DEPTH - 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 7'd0, 128'd0, -1, 1'b1, 7'd13, 128'hBAD, -1, 1'b1, 1'b0);
            setLookups(NO_REG, NO_REG, NO_REG, 7'd12, 7'd13, NO_REG);
            checkOutput($sformatf("stall_fwd_hit_%0d", i), bus.readDataRA_FWD2, fwdExp(d, REG_RA2));
            checkOutput($sformatf("stall_ex_ignored_%0d", i), bus.readDataRB_FWD2, REG_RB2);
        end
        idleCycles(1);
        checkOutput("stall_release_fwd_hit", bus.readDataRA_FWD2, fwdExp(d, REG_RA2));
        setLookups(NO_REG, NO_REG, NO_REG, NO_REG, NO_REG, NO_REG);
        idleCycles(DEPTH + 2);

        // Flush: every slot occupied, only the last slot commits
        $display("[TB] flush");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 7'(20 + i), {4{32'h2000_0000 + i}}, (i == 0) ? DEPTH : -1,
                          1'b1, 7'(40 + i), {4{32'h4000_0000 + i}}, (i == 0) ? DEPTH : -1,
                          1'b0, 1'b0);
        end
        applyStimulus(1'b1, 7'd50, 128'h50, -1, 1'b0, 7'd0, 128'd0, -1, 1'b0, 1'b1);
        setLookups(7'd20, NO_REG, NO_REG, NO_REG, NO_REG, NO_REG);
        checkOutput("flush_last_slot_fwd", bus.readDataRA_FWD1, fwdExp({4{32'h2000_0000}}, REG_RA1));
        idleCycles(1);
        setLookups(7'd21, 7'd50, NO_REG, NO_REG, NO_REG, 7'd43);
        checkOutput("flush_miss_rt21", bus.readDataRA_FWD1, REG_RA1);
        checkOutput("flush_miss_discarded_ex", bus.readDataRB_FWD1, REG_RB1);
        checkOutput("flush_miss_rt43", bus.readDataRC_FWD2, REG_RC2);
        setLookups(NO_REG, NO_REG, NO_REG, NO_REG, NO_REG, NO_REG);
        idleCycles(DEPTH + 2);

        // Flush during stall: last slot holds without writing, then commits
        $display("[TB] flush with stall");
        applyStimulus(1'b1, 7'd60, 128'h60, DEPTH + 1, 1'b0, 7'd0, 128'd0, -1, 1'b0, 1'b0);
        applyStimulus(1'b1, 7'd61, 128'h61, -1, 1'b0, 7'd0, 128'd0, -1, 1'b0, 1'b0);
        idleCycles(DEPTH - 2);
        applyStimulus(1'b0, 7'd0, 128'd0, -1, 1'b0, 7'd0, 128'd0, -1, 1'b1, 1'b1);
        idleCycles(1);
        setLookups(7'd60, 7'd61, NO_REG, NO_REG, NO_REG, NO_REG);
        checkOutput("flush_stall_last_kept", bus.readDataRA_FWD1, fwdExp(128'h60, REG_RA1));
        checkOutput("flush_stall_killed", bus.readDataRB_FWD1, REG_RB1);
        setLookups(NO_REG, NO_REG, NO_REG, NO_REG, NO_REG, NO_REG);
        idleCycles(DEPTH + 2);

        // Asynchronous reset between edges with results in flight
        $display("[TB] async reset");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 7'(70 + i), {4{32'h7000_0000 + i}}, (i == 0) ? DEPTH : -1,
                          1'b0, 7'd0, 128'd0, -1, 1'b0, 1'b0);
        end
        idleCycles(1);
        #6;
        reset = 1'b1;
        setLookups(7'd71, NO_REG, NO_REG, NO_REG, NO_REG, NO_REG);
        checkOutput("arst_wb1_en", {127'd0, bus.regWriteEnable_WB1}, 128'd0);
        checkOutput("arst_wb1_rt", {121'd0, bus.writeRegister_WB1}, 128'd0);
        checkOutput("arst_wb1_data", bus.writeData_WB1, 128'd0);
        checkOutput("arst_fwd_miss", bus.readDataRA_FWD1, REG_RA1);
        @(posedge clk);
        #2;
        // Present a result before release; the first release edge takes it
        bus.regWriteEnable_EX1 = 1'b1;
        bus.readRegisterRT_EX1 = 7'd80;
        bus.result_EX1 = 128'h80;
        q1.push_back('{rt: 7'd80, data: 128'h80, cycle: cyc + DEPTH});
        #2;
        reset = 1'b0;
        idleCycles(1);
        setLookups(7'd71, 7'd80, NO_REG, NO_REG, NO_REG, 7'd72);
        checkOutput("arst_stale_miss_71", bus.readDataRA_FWD1, REG_RA1);
        checkOutput("arst_first_edge_hit", bus.readDataRB_FWD1, fwdExp(128'h80, REG_RB1));
        checkOutput("arst_stale_miss_72", bus.readDataRC_FWD2, REG_RC2);
        setLookups(NO_REG, NO_REG, NO_REG, NO_REG, NO_REG, NO_REG);
        idleCycles(DEPTH + 3);

        // Every queued write must have been seen
        checkOutput("q1_drained", 128'(q1.size()), 128'd0);
        checkOutput("q2_drained", 128'(q2.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
